ghr_update_unit: RTL

- Producer and updater side of the gshare pattern history table interface.
- Holds the speculative global history register (GHR) and drives the PHT read index at fetch.
- Carries each branch's prediction and history snapshot through decode to execute, then drives the PHT training strobe and increment direction.
- Detects mispredictions and restores the GHR from the execute-stage snapshot plus the actual outcome.

---
 rtl/ghr_update_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/ghr_update_unit.sv
// gshare history producer/updater: speculative GHR, PHT read index, F/D/E branch tracking,
// PHT training strobe and mispredict recovery. Optional perf counters under GHR_PERF_CNT_EN.
module ghr_update_unit #(
  parameter int unsigned NUM_GHR_BITS = 5
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic [31:0]             pc_f_i,
  input  logic                    is_branch_f_i,
  input  logic                    predict_taken_i,
  input  logic                    stall_i,
  input  logic                    taken_e_i,
  output logic [NUM_GHR_BITS-1:0] PHTreadaddress_o,
  output logic                    PHTincrement_o,
  output logic                    B_o,
  output logic [NUM_GHR_BITS-1:0] PHTwriteaddress_o,
  output logic                    predict_taken_f_o,
  output logic                    mispredict_o
`ifdef GHR_PERF_CNT_EN
  ,
  output logic [15:0]             br_count_o,
  output logic [15:0]             mispred_count_o
`endif
);

  localparam int unsigned N    = NUM_GHR_BITS;
  localparam int unsigned PC_W = 32;
  localparam int unsigned CNT_W = 16;

  logic [N-1:0] r_ghr;
  logic         r_vld_d;
  logic         r_pred_d;
  logic [N-1:0] r_idx_d;
  logic [N-1:0] r_snap_d;
  logic         r_vld_e;
  logic         r_pred_e;
  logic [N-1:0] r_idx_e;
  logic [N-1:0] r_snap_e;

  logic [N-1:0] w_rd_idx;
  logic [N-1:0] w_ghr_shift;
  logic [N-1:0] w_ghr_restore;
  logic         w_mispredict;
  logic         w_unused_bits;

  // PHT index: history folded with word-aligned PC bits, no carry.
  assign w_rd_idx      = r_ghr ^ pc_f_i[N+1:2];
  assign w_ghr_shift   = {r_ghr[N-2:0], predict_taken_i};
  assign w_ghr_restore = {r_snap_e[N-2:0], taken_e_i};
  assign w_mispredict  = r_vld_e & (taken_e_i != r_pred_e);

  assign w_unused_bits = ^{pc_f_i[PC_W-1:N+2], pc_f_i[1:0], r_snap_e[N-1]};

  assign PHTreadaddress_o  = w_rd_idx;
  assign predict_taken_f_o = is_branch_f_i & predict_taken_i;
  assign B_o               = r_vld_e;
  assign PHTwriteaddress_o = r_idx_e;
  assign PHTincrement_o    = r_vld_e & taken_e_i;
  assign mispredict_o      = w_mispredict;

  // Priority: mispredict flush > stall (hold F/D, bubble D/E) > normal advance.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_ghr    <= '0;
      r_vld_d  <= 1'b0;
      r_pred_d <= 1'b0;
      r_idx_d  <= '0;
      r_snap_d <= '0;
      r_vld_e  <= 1'b0;
      r_pred_e <= 1'b0;
      r_idx_e  <= '0;
      r_snap_e <= '0;
    end else if (w_mispredict) begin
      r_ghr   <= w_ghr_restore;
      r_vld_d <= 1'b0;
      r_vld_e <= 1'b0;
    end else if (stall_i) begin
      r_vld_e <= 1'b0;
    end else begin
      if (is_branch_f_i) begin
        r_ghr <= w_ghr_shift;
      end
      r_vld_d  <= is_branch_f_i;
      r_pred_d <= predict_taken_i;
      r_idx_d  <= w_rd_idx;
      r_snap_d <= r_ghr;
      r_vld_e  <= r_vld_d;
      r_pred_e <= r_pred_d;
      r_idx_e  <= r_idx_d;
      r_snap_e <= r_snap_d;
    end
  end

`ifdef GHR_PERF_CNT_EN
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mis_cnt;

  // Saturating event counters.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (r_vld_e && (r_br_cnt != {CNT_W{1'b1}})) begin
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      end
      if (w_mispredict && (r_mis_cnt != {CNT_W{1'b1}})) begin
        r_mis_cnt <= r_mis_cnt + CNT_W'(1);
      end
    end
  end

  assign br_count_o      = r_br_cnt;
  assign mispred_count_o = r_mis_cnt;
`endif

endmodule
